// File: rtl/fetch_unit.sv
// fetch_unit -- instruction-fetch stage of the 5-stage RISC-V pipeline.
//
// Owns the PC and talks to a variable-latency request/response instruction
// memory. One instruction is fetched at a time: REQ issues the request, WAIT
// collects the response into ibuf, and HOLD presents it to the F/D register
// until the hazard unit lets the pipeline advance. A taken branch/jump from
// execute (redirect) overrides everything. A response that belongs to a
// request made before the redirect is swallowed in DROP.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   stall_f       hold the current PC/instruction while in HOLD
//   redirect      taken branch/jump this cycle, target on redirect_pc
//   imem_req/imem_addr/imem_ready         request channel (addr = PC)
//   imem_rvalid/imem_rdata                response channel
//   instr_f/pc_f/pcplus4_f                to the F/D register
//   fetch_busy    no valid instruction held (hazard unit bubbles F/D)
module fetch_unit #(
  parameter int unsigned          DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_f,
  input  logic                  redirect,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_ready,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] instr_f,
  output logic [DATA_WIDTH-1:0] pc_f,
  output logic [DATA_WIDTH-1:0] pcplus4_f,
  output logic                  fetch_busy
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_t;

  localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   pc_q, pc_d;
  logic [DATA_WIDTH-1:0]   ibuf_q, ibuf_d;
  logic                    ibuf_valid_q, ibuf_valid_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      ibuf_q       <= '0;
      ibuf_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ibuf_q       <= ibuf_d;
      ibuf_valid_q <= ibuf_valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ibuf_d       = ibuf_q;
    ibuf_valid_d = ibuf_valid_q;

    if (redirect) begin
      // The redirect target replaces the PC immediately. If a request has
      // been accepted but not yet answered, its response is stale and must
      // be absorbed in DROP before a new request can go out.
      pc_d         = redirect_pc;
      ibuf_valid_d = 1'b0;
      unique case (state_q)
        S_REQ:   state_d = imem_ready  ? S_DROP : S_REQ;
        S_WAIT:  state_d = imem_rvalid ? S_REQ  : S_DROP;
        S_HOLD:  state_d = S_REQ;
        S_DROP:  state_d = imem_rvalid ? S_REQ  : S_DROP;
        default: state_d = S_REQ;
      endcase
    end else begin
      // A response seen in REQ or HOLD is a protocol violation and ignored.
      unique case (state_q)
        S_REQ: begin
          if (imem_ready) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            ibuf_d       = imem_rdata;
            ibuf_valid_d = 1'b1;
            state_d      = S_HOLD;
          end
        end
        S_HOLD: begin
          if (!stall_f) begin
            pc_d         = pc_q + PC_STEP;
            ibuf_valid_d = 1'b0;
            state_d      = S_REQ;
          end
        end
        S_DROP: begin
          if (imem_rvalid) state_d = S_REQ;
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  assign imem_req   = (state_q == S_REQ);
  assign imem_addr  = pc_q;
  assign pc_f       = pc_q;
  assign pcplus4_f  = pc_q + PC_STEP;
  assign instr_f    = ibuf_valid_q ? ibuf_q : NOP_INSTR;
  assign fetch_busy = !ibuf_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- directed, table-driven bench for fetch_unit.
// Each table row holds the inputs driven for one cycle and the outputs
// expected during that cycle (before the clock edge that consumes the inputs).
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_f;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr_f;
  logic [31:0] pc_f;
  logic [31:0] pcplus4_f;
  logic        fetch_busy;

  int checks = 0;
  int errors = 0;

  fetch_unit #(
    .DATA_WIDTH(32),
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall_f    (stall_f),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .instr_f    (instr_f),
    .pc_f       (pc_f),
    .pcplus4_f  (pcplus4_f),
    .fetch_busy (fetch_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        exp_req;
    logic [31:0] exp_pc;
    logic [31:0] exp_p4;
    logic [31:0] exp_instr;
    logic        exp_busy;
  } vec_t;

  vec_t vecs[64];
  int   nvec = 0;

  // Append one row: inputs, then expected req, pc (= imem_addr), pc+4, instr, busy.
  task automatic add(input logic st, input logic rd, input logic [31:0] rp,
                     input logic rdy, input logic rv, input logic [31:0] rdt,
                     input logic e_req, input logic [31:0] e_pc, input logic [31:0] e_p4,
                     input logic [31:0] e_ins, input logic e_busy);
    vecs[nvec] = '{st, rd, rp, rdy, rv, rdt, e_req, e_pc, e_p4, e_ins, e_busy};
    nvec++;
  endtask

  task automatic check(input string name, input logic e_req, input logic [31:0] e_pc,
                       input logic [31:0] e_p4, input logic [31:0] e_ins, input logic e_busy);
    checks++;
    if (imem_req !== e_req || imem_addr !== e_pc || pc_f !== e_pc ||
        pcplus4_f !== e_p4 || instr_f !== e_ins || fetch_busy !== e_busy) begin
      errors++;
      $display("FAIL %s: got req=%0b addr=%h pc=%h p4=%h instr=%h busy=%0b, want req=%0b pc=%h p4=%h instr=%h busy=%0b",
               name, imem_req, imem_addr, pc_f, pcplus4_f, instr_f, fetch_busy,
               e_req, e_pc, e_p4, e_ins, e_busy);
    end else begin
      $display("ok   %s: req=%0b pc=%h instr=%h busy=%0b", name, imem_req, pc_f, instr_f, fetch_busy);
    end
  endtask

  task automatic drive(input logic st, input logic rd, input logic [31:0] rp,
                       input logic rdy, input logic rv, input logic [31:0] rdt);
    stall_f = st; redirect = rd; redirect_pc = rp;
    imem_ready = rdy; imem_rvalid = rv; imem_rdata = rdt;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 32'h0, 0, 0, 32'h0);

    // ---- table: stall, redir, rpc, ready, rvalid, rdata | req, pc, pc+4, instr, busy
    // basic fetch at 0 with 1-cycle memory
    add(0,0,32'h0,          1,0,32'h0,        1,32'h0,32'h4,NOP,1);          // REQ accepted
    add(0,0,32'h0,          0,1,32'h00500093, 0,32'h0,32'h4,NOP,1);          // WAIT, response
    add(0,0,32'h0,          0,0,32'h0,        0,32'h0,32'h4,32'h00500093,0); // HOLD, advance
    // ready low for 3 cycles, response 2 cycles after acceptance; stall ignored in REQ/WAIT
    add(0,0,32'h0,          0,0,32'h0,        1,32'h4,32'h8,NOP,1);
    add(1,0,32'h0,          0,0,32'h0,        1,32'h4,32'h8,NOP,1);
    add(0,0,32'h0,          0,0,32'h0,        1,32'h4,32'h8,NOP,1);
    add(0,0,32'h0,          1,0,32'h0,        1,32'h4,32'h8,NOP,1);
    add(1,0,32'h0,          0,0,32'h0,        0,32'h4,32'h8,NOP,1);
    add(0,0,32'h0,          0,1,32'h00A00113, 0,32'h4,32'h8,NOP,1);
    add(0,0,32'h0,          0,0,32'h0,        0,32'h4,32'h8,32'h00A00113,0);
    // HOLD at 0x8 stalled 4 cycles; stray rvalid during HOLD ignored
    add(0,0,32'h0,          1,0,32'h0,        1,32'h8,32'hC,NOP,1);
    add(0,0,32'h0,          0,1,32'h00100193, 0,32'h8,32'hC,NOP,1);
    add(1,0,32'h0,          0,0,32'h0,        0,32'h8,32'hC,32'h00100193,0);
    add(1,0,32'h0,          0,1,32'h11111111, 0,32'h8,32'hC,32'h00100193,0);
    add(1,0,32'h0,          0,0,32'h0,        0,32'h8,32'hC,32'h00100193,0);
    add(1,0,32'h0,          0,0,32'h0,        0,32'h8,32'hC,32'h00100193,0);
    add(0,0,32'h0,          0,0,32'h0,        0,32'h8,32'hC,32'h00100193,0);
    add(0,0,32'h0,          1,0,32'h0,        1,32'hC,32'h10,NOP,1);
    add(0,0,32'h0,          0,1,32'h00200213, 0,32'hC,32'h10,NOP,1);
    add(0,0,32'h0,          0,0,32'h0,        0,32'hC,32'h10,32'h00200213,0);
    // redirect to 0x40 while waiting on 0x10; stale DEADBEEF arrives 2 cycles later
    add(0,0,32'h0,          1,0,32'h0,        1,32'h10,32'h14,NOP,1);
    add(0,1,32'h40,         0,0,32'h0,        0,32'h10,32'h14,NOP,1);
    add(0,0,32'h0,          0,0,32'h0,        0,32'h40,32'h44,NOP,1);        // DROP
    add(0,0,32'h0,          0,1,32'hDEADBEEF, 0,32'h40,32'h44,NOP,1);        // DROP consumes
    add(0,0,32'h0,          0,0,32'h0,        1,32'h40,32'h44,NOP,1);        // REQ 0x40
    add(0,0,32'h0,          1,0,32'h0,        1,32'h40,32'h44,NOP,1);
    // redirect to 0x80 with rvalid in WAIT: response dropped, straight to REQ
    add(0,0,32'h0,          0,0,32'h0,        0,32'h40,32'h44,NOP,1);
    add(0,1,32'h80,         0,1,32'hCAFEBABE, 0,32'h40,32'h44,NOP,1);
    add(0,0,32'h0,          1,0,32'h0,        1,32'h80,32'h84,NOP,1);
    add(0,0,32'h0,          0,1,32'h00300293, 0,32'h80,32'h84,NOP,1);
    // redirect together with stall in HOLD: redirect wins
    add(1,1,32'h100,        0,0,32'h0,        0,32'h80,32'h84,32'h00300293,0);
    add(0,0,32'h0,          0,0,32'h0,        1,32'h100,32'h104,NOP,1);
    // redirect in REQ with ready -> DROP
    add(0,1,32'h200,        1,0,32'h0,        1,32'h100,32'h104,NOP,1);
    add(0,0,32'h0,          1,0,32'h0,        0,32'h200,32'h204,NOP,1);      // DROP, no req
    add(0,0,32'h0,          0,1,32'h55555555, 0,32'h200,32'h204,NOP,1);
    // redirect in REQ without ready -> REQ; wrap of pc+4 at top of space
    add(0,1,32'hFFFF_FFFC,  0,0,32'h0,        1,32'h200,32'h204,NOP,1);
    add(0,0,32'h0,          1,0,32'h0,        1,32'hFFFF_FFFC,32'h0,NOP,1);
    add(0,0,32'h0,          0,1,32'h00400313, 0,32'hFFFF_FFFC,32'h0,NOP,1);
    add(0,0,32'h0,          0,0,32'h0,        0,32'hFFFF_FFFC,32'h0,32'h00400313,0);
    add(0,0,32'h0,          0,0,32'h0,        1,32'h0,32'h4,NOP,1);          // pc wrapped to 0

    // ---- reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 check("reset", 1'b1, 32'h0, 32'h4, NOP, 1'b1);

    // ---- table
    for (int i = 0; i < nvec; i++) begin
      drive(vecs[i].stall, vecs[i].redir, vecs[i].rpc,
            vecs[i].ready, vecs[i].rvalid, vecs[i].rdata);
      #1 check($sformatf("vec%0d", i), vecs[i].exp_req, vecs[i].exp_pc,
               vecs[i].exp_p4, vecs[i].exp_instr, vecs[i].exp_busy);
      @(negedge clk);
    end

    // ---- reset mid-transaction while in DROP: back to REQ at RESET_PC, no DROP
    drive(0, 1, 32'h300, 1, 0, 32'h0);                 // REQ accepted + redirect -> DROP
    @(negedge clk);
    drive(0, 0, 32'h0, 0, 0, 32'h0);
    #1 check("drop_before_rst", 1'b0, 32'h300, 32'h304, NOP, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1 check("after_rst", 1'b1, 32'h0, 32'h4, NOP, 1'b1);
    drive(0, 0, 32'h0, 1, 0, 32'h0);
    @(negedge clk);
    drive(0, 0, 32'h0, 0, 1, 32'h00600393);
    @(negedge clk);
    drive(0, 0, 32'h0, 0, 0, 32'h0);
    // the first response after reset is kept, so no DROP was left pending
    #1 check("post_rst_fetch", 1'b0, 32'h0, 32'h4, 32'h00600393, 1'b0);
    @(negedge clk);
    #1 check("post_rst_next", 1'b1, 32'h4, 32'h8, NOP, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
